aec_expr_tx: RTL and testbench

Transmit side of the AEC character interface. Accepts an expression as a burst of 5-bit token codes into an internal FIFO and serialises it as ASCII characters on ascii_out/ready_out, terminated with '='. Waits for the evaluator's valid/result before sending the next expression and returns the captured result to the host. Sits between the host/test driver and the AEC evaluator.

---
 rtl/aec_expr_tx.sv | 128 ++++++++++++
 tb/tb_aec_expr_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/aec_expr_tx.sv
// aec_expr_tx: loads a burst of 5-bit token codes into a FIFO, sends them as ASCII terminated
// by '=', then waits for the evaluator result (or a timeout) before the next expression.
// Ports: tok_we/tok_in/tok_last load tokens; full/busy show load status; ready_out/ascii_out
// drive the evaluator; eval_valid/eval_result return its result; done/result_out hand the
// result back; err pulses on timeout, overflow or an illegal token.
// Optional macro AEC_PAREN_CHECK_EN rejects expressions with unbalanced parentheses.
module aec_expr_tx #(
  parameter int DEPTH  = 16,
  parameter int TO_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_we,
  input  logic [4:0] tok_in,
  input  logic       tok_last,
  output logic       full,
  output logic       busy,
  output logic       ready_out,
  output logic [7:0] ascii_out,
  input  logic       eval_valid,
  input  logic [6:0] eval_result,
  output logic       done,
  output logic [6:0] result_out,
  output logic       err
);
  localparam int CW = $clog2(DEPTH);
  localparam int TW = $clog2(TO_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, TERM, WAIT, GUARD} state_t;
  state_t        state_q;
  logic [4:0]    mem_q [DEPTH];
  logic [CW-1:0] cnt_q, rd_q;
  logic [TW-1:0] tmr_q;
  logic [7:0]    ascii_q;
  logic [6:0]    result_q;
  logic          ready_q, done_q, err_q;
  logic          wr, bad, push;
  logic [4:0]    first_tok;
  function automatic logic [7:0] enc(input logic [4:0] t);
    return t < 5'd10 ? 8'h30 + {3'b0, t} :
           t < 5'd16 ? 8'h57 + {3'b0, t} :
           t == 5'd16 ? 8'h28 : t == 5'd17 ? 8'h29 :
           t == 5'd18 ? 8'h2A : t == 5'd19 ? 8'h2B : 8'h2D;
  endfunction
  assign busy       = !(state_q == IDLE || state_q == LOAD);
  assign full       = busy || cnt_q == CW'(DEPTH - 1);
  assign ready_out  = ready_q;
  assign ascii_out  = ascii_q;
  assign done       = done_q;
  assign result_out = result_q;
  assign err        = err_q;
  assign wr         = tok_we && !full;
  assign push       = wr && !bad;
  // A single-token expression has nothing in the FIFO yet, so its first char comes straight from the input.
  assign first_tok  = cnt_q == '0 ? tok_in : mem_q[0];
`ifdef AEC_PAREN_CHECK_EN
  logic [4:0] depth_q, depth_d;
  assign depth_d = depth_q + {4'b0, tok_in == 5'd16} - {4'b0, tok_in == 5'd17};
  assign bad = tok_in > 5'd20 || (!tok_last && cnt_q == CW'(DEPTH - 2)) ||
               (tok_in == 5'd17 && depth_q == '0) || (tok_last && depth_d != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) depth_q <= '0;
    else if (wr) depth_q <= (bad || tok_last) ? '0 : depth_d;
`else
  assign bad = tok_in > 5'd20 || (!tok_last && cnt_q == CW'(DEPTH - 2));
`endif
  always_ff @(posedge clk)
    if (push) mem_q[cnt_q] <= tok_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      tmr_q    <= '0;
      ascii_q  <= 8'h00;
      result_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE, LOAD: if (wr) begin
          if (bad) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= tok_last ? SEND : LOAD;
            if (tok_last) begin
              ascii_q <= enc(first_tok);
              ready_q <= 1'b1;
              rd_q    <= CW'(1);
            end
          end
        end
        SEND: begin
          ascii_q <= rd_q == cnt_q ? 8'h3D : enc(mem_q[rd_q]);
          rd_q    <= rd_q + 1'b1;
          state_q <= rd_q == cnt_q ? TERM : SEND;
        end
        TERM: begin
          ascii_q <= 8'h00;
          tmr_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          tmr_q <= tmr_q + 1'b1;
          if (eval_valid) begin
            result_q <= eval_result;
            done_q   <= 1'b1;
            state_q  <= GUARD;
          end else if (tmr_q == TW'(TO_CYC - 1)) begin
            err_q   <= 1'b1;
            state_q <= GUARD;
          end
        end
        GUARD: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aec_expr_tx.sv
// tb_aec_expr_tx: scoreboard bench; the driver predicts every output event with its cycle, the monitor checks them.
module tb_aec_expr_tx;
  localparam int DEPTH  = 16;
  localparam int TO_CYC = 255;
  logic       clk = 0, rst = 1;
  logic       tok_we = 0, tok_last = 0, eval_valid = 0;
  logic [4:0] tok_in = 0;
  logic [6:0] eval_result = 0;
  logic       full, busy, ready_out, done, err;
  logic [7:0] ascii_out;
  logic [6:0] result_out;
  aec_expr_tx #(.DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .tok_we(tok_we), .tok_in(tok_in), .tok_last(tok_last),
    .full(full), .busy(busy), .ready_out(ready_out), .ascii_out(ascii_out),
    .eval_valid(eval_valid), .eval_result(eval_result), .done(done),
    .result_out(result_out), .err(err));
  always #5 clk = ~clk;
  typedef struct {int kind; int val; int rdy; int at;} ev_t;
  ev_t        exp_q[$];
  logic [4:0] tq[$];
  bit         no_last;
  int         cyc = 0, passes = 0, total = 0, last_res = 0;
  string      charset = "0123456789abcdef()*+-";
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, int act, int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_ev(int kind, int val, int rdy, int at);
    ev_t e;
    e.kind = kind; e.val = val; e.rdy = rdy; e.at = at;
    exp_q.push_back(e);
  endtask
  task automatic check_ev(int kind, int val, int rdy);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d val %0h at cycle %0d expected none", kind, val, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_value", val, e.val);
    chk("event_ready", rdy, e.rdy);
    chk("event_cycle", cyc, e.at);
  endtask
  always @(negedge clk) if (!rst) begin
    if (ascii_out != 8'h00 || ready_out) check_ev(0, ascii_out, ready_out);
    if (done) check_ev(1, result_out, 0);
    if (err) check_ev(2, 0, 0);
  end
  // Reference: writes one token per cycle; returns the '=' cycle or -1 when the expression is rejected.
  task automatic load_expr(output int term_cyc);
    int  depth = 0;
    bit  last, bad;
    term_cyc = -1;
    for (int i = 0; i < tq.size(); i++) begin
      last = (i == tq.size() - 1) && !no_last;
      bad  = tq[i] > 20 || (!last && i + 1 == DEPTH - 1);
`ifdef AEC_PAREN_CHECK_EN
      if (tq[i] == 17 && depth == 0) bad = 1;
      depth += int'(tq[i] == 16) - int'(tq[i] == 17);
      if (last && depth != 0) bad = 1;
`endif
      tok_we = 1; tok_in = tq[i]; tok_last = last;
      if (bad) push_ev(2, 0, 0, cyc + 1);
      else if (last) begin
        for (int j = 0; j < tq.size(); j++) push_ev(0, int'(charset[tq[j]]), int'(j == 0), cyc + 1 + j);
        push_ev(0, int'("="), 0, cyc + 1 + tq.size());
        term_cyc = cyc + 1 + tq.size();
      end
      tick();
      tok_we = 0; tok_last = 0;
      if (bad) return;
    end
  endtask
  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin tick(); g++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask
  // Evaluator stand-in: returns res `dly` cycles into WAIT while spamming ignored token writes.
  task automatic respond(int term_cyc, int dly, int res);
    while (cyc < term_cyc + 1 + dly) begin
      tok_we = 1; tok_in = 5'd7; tok_last = 1;
      tick();
    end
    tok_we = 0; tok_last = 0;
    eval_valid = 1; eval_result = 7'(res);
    push_ev(1, res, 0, cyc + 1);
    last_res = res;
    tick();
    eval_valid = 0;
    tick();
    drain();
  endtask
  initial begin
    int t;
    rst = 1;
    tick(); tick();
    chk("rst_full", full, 0); chk("rst_busy", busy, 0); chk("rst_ready", ready_out, 0);
    chk("rst_ascii", ascii_out, 0); chk("rst_done", done, 0); chk("rst_result", result_out, 0);
    chk("rst_err", err, 0);
    rst = 0;
    tick();
    no_last = 0;
    tq = '{5'd3, 5'd19, 5'd5};
    load_expr(t);
    chk("busy_after_close", busy, 1); chk("full_while_busy", full, 1);
    respond(t, 3, 8);
    chk("result_held", result_out, 8);
    tq = '{5'd16, 5'd2, 5'd19, 5'd10, 5'd17, 5'd18, 5'd3};
    load_expr(t);
    respond(t, 0, 36);
    tq = '{5'd4, 5'd18, 5'd2};
    load_expr(t);
    respond(t, 5, 8);
    no_last = 1;
    tq = {};
    for (int i = 0; i < 15; i++) tq.push_back(5'(i % 10));
    load_expr(t);
    drain();
    chk("ovf_busy", busy, 0); chk("ovf_full", full, 0);
    no_last = 0;
    tq = '{5'd1, 5'd20, 5'd1};
    load_expr(t);
    push_ev(2, 0, 0, t + 1 + TO_CYC);
    drain();
    chk("timeout_result_kept", result_out, last_res);
    tick();
    chk("timeout_idle", busy, 0);
    eval_valid = 1;
    repeat (4) tick();
    eval_valid = 0;
    tick();
    tq = '{5'd16, 5'd1};
    load_expr(t);
    if (t >= 0) respond(t, 2, 5); else drain();
    tq = '{5'd9, 5'd25, 5'd1};
    load_expr(t);
    drain();
    for (int n = 0; n < 25; n++) begin
      int len = $urandom_range(1, 15);
      tq = {};
      no_last = 0;
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 18);
        tq.push_back(5'(r < 16 ? r : r + 2));
      end
      if ($urandom_range(0, 5) == 0) tq[$urandom_range(0, len - 1)] = 5'($urandom_range(21, 31));
      if ($urandom_range(0, 7) == 0) begin
        no_last = 1;
        while (tq.size() < 15) tq.push_back(5'd0);
      end
      load_expr(t);
      if (t >= 0) respond(t, $urandom_range(0, 20), $urandom_range(0, 127));
      else drain();
      tick();
    end
    no_last = 0;
    tq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd1};
    load_expr(t);
    tick(); tick();
    #1 rst = 1;
    #1;
    chk("midrst_ascii", ascii_out, 0); chk("midrst_ready", ready_out, 0);
    chk("midrst_busy", busy, 0); chk("midrst_full", full, 0);
    chk("midrst_result", result_out, 0); chk("midrst_done", done, 0);
    exp_q.delete();
    tick();
    rst = 0;
    tick();
    tq = '{5'd2, 5'd18, 5'd11};
    load_expr(t);
    respond(t, 1, 22);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
